ibex_csr_shadow_monitor: RTL and testbench

// - Read-side integrity monitor for a bank of shadowed CSR primitives.
// - Walks the rd_error outputs of NumCsrs CSRs and latches the first failing index (sticky).
// - Counts detected faults and raises a four-phase alert handshake towards the alert/reset logic.
// - Sits beside the CSR file in the core; consumes the storage side's error outputs, never writes CSRs.

---
 rtl/ibex_csr_shadow_monitor.sv | 135 +++++++++++++
 tb/tb_ibex_csr_shadow_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_csr_shadow_monitor.sv
// Read-side integrity monitor for shadowed CSRs: background scan, sticky first-fault capture,
// saturating fault counter and four-phase alert. Optional: IBEX_CSR_MON_IMMEDIATE_EN (check all bits every cycle).
module ibex_csr_shadow_monitor #(
    parameter int unsigned NumCsrs    = 8,
    parameter int unsigned ScanPeriod = 16,
    parameter int unsigned CntWidth   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scan_en_i,
    input  logic [NumCsrs-1:0]         csr_rd_error_i,
    input  logic                       clear_i,
    input  logic                       alert_ack_i,
    output logic                       alert_req_o,
    output logic                       err_valid_o,
    output logic [$clog2(NumCsrs)-1:0] err_idx_o,
    output logic [CntWidth-1:0]        err_cnt_o,
    output logic [$clog2(NumCsrs)-1:0] scan_ptr_o
);
    localparam int unsigned IdxW = $clog2(NumCsrs);
    localparam int unsigned PerW = (ScanPeriod > 1) ? $clog2(ScanPeriod) : 1;
    localparam logic [PerW-1:0] PerLast = PerW'(ScanPeriod - 1);
    localparam logic [IdxW-1:0] PtrLast = IdxW'(NumCsrs - 1);

    logic [PerW-1:0]     period_q;
    logic [IdxW-1:0]     ptr_q;
    logic                valid_q;
    logic [IdxW-1:0]     idx_q;
    logic [CntWidth-1:0] cnt_q;
    logic                scan_hit;
    logic                detect;
    logic [IdxW-1:0]     hit_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            ptr_q    <= '0;
        end else if (scan_en_i) begin
            if (period_q == PerLast) begin
                period_q <= '0;
                ptr_q    <= (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
            end else begin
                period_q <= period_q + 1'b1;
            end
        end
    end

    assign scan_hit = scan_en_i & csr_rd_error_i[ptr_q];

`ifdef IBEX_CSR_MON_IMMEDIATE_EN
    logic [IdxW-1:0] low_idx;

    always_comb begin
        low_idx = '0;
        for (int i = int'(NumCsrs) - 1; i >= 0; i--) begin
            if (csr_rd_error_i[i]) low_idx = IdxW'(i);
        end
    end

    // A scan hit is always also an immediate hit, so both paths collapse into one event.
    assign detect  = scan_hit | (|csr_rd_error_i);
    assign hit_idx = (|csr_rd_error_i) ? low_idx : ptr_q;
`else
    assign detect  = scan_hit;
    assign hit_idx = ptr_q;
`endif

    // A detection outranks a simultaneous clear: the new fault restarts the record at count 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (detect) begin
            if (clear_i || !valid_q) begin
                valid_q <= 1'b1;
                idx_q   <= hit_idx;
            end
            if (clear_i) begin
                cnt_q <= CntWidth'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (clear_i) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end
    end

    // state     | meaning
    // StIdle    | no alert outstanding, waiting for a captured fault
    // StReq     | alert_req high, waiting for ack (clear ignored here)
    // StWaitLow | req dropped, waiting for ack to return low
    // StDone    | handshake complete, waiting for clear
    typedef enum logic [1:0] {StIdle, StReq, StWaitLow, StDone} state_e;

    state_e state_q, state_d;
    logic   req_q, req_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (!clear_i && valid_q) state_d = StReq;
            StReq:     if (alert_ack_i) state_d = StWaitLow;
            StWaitLow: begin
                if (clear_i) state_d = StIdle;
                else if (!alert_ack_i) state_d = StDone;
            end
            StDone:    if (clear_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_d = (state_d == StReq);
    end

    assign alert_req_o = req_q;
    assign err_valid_o = valid_q;
    assign err_idx_o   = idx_q;
    assign err_cnt_o   = cnt_q;
    assign scan_ptr_o  = ptr_q;

endmodule

// File: tb/tb_ibex_csr_shadow_monitor.sv
// Scoreboard bench for ibex_csr_shadow_monitor: a behavioural model predicts every cycle's outputs,
// a separate monitor compares them after each clock edge.
module tb_ibex_csr_shadow_monitor;
    localparam int N       = 8;
    localparam int P       = 16;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int H_IDLE  = 0;
    localparam int H_REQ   = 1;
    localparam int H_WAIT  = 2;
    localparam int H_DONE  = 3;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           scan_en = 1'b0;
    logic           clear   = 1'b0;
    logic           ack     = 1'b0;
    logic [N-1:0]   err_in  = '0;
    logic           alert_req;
    logic           err_valid;
    logic [2:0]     err_idx;
    logic [CW-1:0]  err_cnt;
    logic [2:0]     scan_ptr;

    ibex_csr_shadow_monitor #(.NumCsrs(N), .ScanPeriod(P), .CntWidth(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .scan_en_i      (scan_en),
        .csr_rd_error_i (err_in),
        .clear_i        (clear),
        .alert_ack_i    (ack),
        .alert_req_o    (alert_req),
        .err_valid_o    (err_valid),
        .err_idx_o      (err_idx),
        .err_cnt_o      (err_cnt),
        .scan_ptr_o     (scan_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit req;
        bit valid;
        int idx;
        int cnt;
        int ptr;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    int     checks = 0;
    int     errors = 0;

    longint en_cycles = 0;
    bit     m_valid   = 0;
    int     m_idx     = 0;
    int     m_cnt     = 0;
    int     m_hs      = H_IDLE;
    bit     m_req     = 0;
    int     req_age   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [N-1:0] bitv(int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // The pointer is just the number of enabled cycles divided into periods, modulo the bank size.
    function automatic int model_ptr();
        return int'((en_cycles / P) % N);
    endfunction

    task automatic model_step();
        bit hit;
        int hidx;
        int ptr;
        int nxt;
        if (!rst_n) begin
            en_cycles = 0;
            m_valid   = 0;
            m_idx     = 0;
            m_cnt     = 0;
            m_hs      = H_IDLE;
            m_req     = 0;
            return;
        end
        ptr  = model_ptr();
        hit  = scan_en && err_in[ptr];
        hidx = ptr;
`ifdef IBEX_CSR_MON_IMMEDIATE_EN
        if (err_in != '0) begin
            hit = 1;
            for (int i = 0; i < N; i++) begin
                if (err_in[i]) begin
                    hidx = i;
                    break;
                end
            end
        end
`endif
        nxt = m_hs;
        case (m_hs)
            H_IDLE: if (!clear && m_valid) nxt = H_REQ;
            H_REQ:  if (ack) nxt = H_WAIT;
            H_WAIT: nxt = clear ? H_IDLE : (!ack ? H_DONE : H_WAIT);
            H_DONE: if (clear) nxt = H_IDLE;
            default: nxt = H_IDLE;
        endcase
        m_hs  = nxt;
        m_req = (m_hs == H_REQ);
        if (hit) begin
            if (clear || !m_valid) begin
                m_valid = 1;
                m_idx   = hidx;
            end
            m_cnt = clear ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        end else if (clear) begin
            m_valid = 0;
            m_idx   = 0;
            m_cnt   = 0;
        end
        if (scan_en) en_cycles++;
    endtask

    task automatic step(bit r, bit en, logic [N-1:0] er, bit c, bit a);
        rst_n   = r;
        scan_en = en;
        err_in  = er;
        clear   = c;
        ack     = a;
        model_step();
        exp_q.push_back('{req: m_req, valid: m_valid, idx: m_idx, cnt: m_cnt, ptr: model_ptr()});
        @(negedge clk);
    endtask

    function automatic bit auto_ack();
        if (m_hs == H_REQ) req_age++;
        else req_age = 0;
        return (m_hs == H_REQ && req_age > 3) || (m_hs == H_WAIT && $urandom_range(0, 3) == 0);
    endfunction

    task automatic run(int n, bit en, logic [N-1:0] er);
        for (int i = 0; i < n; i++) step(1, en, er, 0, auto_ack());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alert_req", 32'(alert_req), 32'(e.req));
                chk("err_valid", 32'(err_valid), 32'(e.valid));
                chk("err_idx",   32'(err_idx),   e.idx);
                chk("err_cnt",   32'(err_cnt),   e.cnt);
                chk("scan_ptr",  32'(scan_ptr),  e.ptr);
            end
        end
    end

    initial begin
        int pt;
        logic [N-1:0] er;
        repeat (3) step(0, 0, '0, 0, 0);

        run(N * P + 4, 1, '0);

        run(2 * N * P, 1, bitv(5));
        step(1, 1, '0, 1, 0);
        run(6, 1, '0);

        run(N * P, 1, bitv(2));
        run(1200, 1, bitv(2) | bitv(6));

        pt = model_ptr();
        step(1, 1, bitv(pt), 1, 0);
        for (int i = 0; i < 10 && m_hs != H_REQ; i++) step(1, 1, '0, 0, 0);
        step(1, 1, '0, 1, 0);
        step(1, 1, '0, 0, 0);

        rst_n = 1'b0;
        #1;
        chk("async_rst_req",   32'(alert_req), 0);
        chk("async_rst_valid", 32'(err_valid), 0);
        chk("async_rst_cnt",   32'(err_cnt),   0);
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        run(5, 0, bitv(3) | bitv(7));
        step(1, 0, '0, 1, 0);
        run(N * P, 1, '0);

        for (int i = 0; i < 3000; i++) begin
            er = ($urandom_range(0, 15) == 0) ? bitv($urandom_range(0, N - 1)) : '0;
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), er,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0) ? 1'b1 : auto_ack());
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
